clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Runtime-programmable integer clock divider, the parametrised successor to the fixed odd-ratio `clock` divider. It divides `clk` by any integer N from 2 to 2^CNT_W-1 and produces a registered `divided_clk` and a one-cycle `tick` strobe at each output period start. A new divisor is accepted over a valid/ready handshake and takes effect only at a period boundary, so the output never glitches. It sits beside the existing clock logic and feeds slow-rate enables and derived clocks to downstream blocks.

## Interface
- `CNT_W`, 8: width of the divisor and of the internal counter.
- `DEFAULT_DIV`, 5: divisor loaded at reset; must be in the range 2..2^CNT_W-1.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  divider enable.
- `div_in`  in  CNT_W  requested divisor N.
- `div_valid`  in  1  `div_in` is valid this cycle.
- `div_ready`  out  1  block can accept a new divisor.
- `divided_clk`  out  1  divided clock, registered.
- `tick`  out  1  one-cycle pulse coincident with each rising edge of `divided_clk`.
- `cur_div`  out  CNT_W  divisor currently in effect.

## Operation
- State:
  - `cnt` counts 0..N-1.
  - `div_cur` holds the active divisor.
  - `div_pend` and `pend_v` hold a pending divisor.
- High length: H = N/2 for even N, (N+1)/2 for odd N (duty-cycle handling is under Configuration).
- Output registers:
  - `divided_clk` <= en & (cnt < H).
  - `tick` <= en & (cnt == 0).
- Counting with `en`=1: `cnt` increments; at `cnt`==N-1 it wraps to 0.
- Pending-divisor handling at the wrap:
  - If `pend_v`=1, `div_cur` <= `div_pend` and `pend_v` <= 0.
  - The new period starts with the new N.
- Handshake:
  - `div_ready` = !`pend_v`.
  - Transfer occurs when `div_valid` & `div_ready`; `div_pend` <= `div_in`, `pend_v` <= 1.
  - Only one divisor can be pending at a time.
- Clamping: `div_in` values 0 and 1 are clamped to 2 at capture, so `cur_div` never reads below 2.
- `en`=0:
  - `cnt` <= 0; `divided_clk` and `tick` are 0 from the next cycle.
  - A pending divisor is applied immediately, on the next edge.
  - Re-enabling starts a fresh period at `cnt`=0.
- Simultaneous capture and wrap: when a transfer occurs on the same cycle as the wrap, the captured value is applied at the *next* wrap, not this one.
- Reset mid-operation clears everything regardless of `pend_v`; the pending divisor is discarded.

## Timing
- Reset values:
  - `cnt`=0, `div_cur`=DEFAULT_DIV, `pend_v`=0.
  - `divided_clk`=0, `tick`=0, `div_ready`=1, `cur_div`=DEFAULT_DIV.
- Latency:
  - `divided_clk` and `tick` lag `cnt` by one clock.
  - With `en` held high during reset release, the first `tick` and the first `divided_clk` rise occur on the 1st edge after reset deasserts.
- Output period is exactly N `clk` cycles in steady state.
- Divisor change:
  - `div_ready` falls the edge after the transfer.
  - It returns to 1 the edge after the wrap that applied the new divisor.
  - The first period with the new N begins on that same wrap.
- `cur_div` updates on the same edge as `div_cur`.

## Configuration
- Macro: `CLK_DIV_PROG_DUTY50_EN`.
- Defined:
  - For odd N, the high phase is (N-1)/2 cycles from the posedge register.
  - It is ORed with a copy of that register re-sampled on the falling edge of `clk`.
  - The result is exactly 50% duty, a high time of N/2 clock periods.
  - `tick` is unaffected.
  - Even N is unchanged.
- Not defined:
  - Odd N gives high for (N+1)/2 cycles and low for (N-1)/2 cycles.
  - No negedge flop is instantiated, so all logic is single-edge.

## Structure
- Package `clk_div_pkg` holds:
  - `DIV_MIN` = 2.
  - Default `CNT_W`.
  - A `div_t` typedef of width CNT_W.
  - The clamp function.
- Sub-module `clk_div_duty50`:
  - Takes the posedge high-phase signal and produces the duty-corrected output.
  - Holds the negedge flop, which is also cleared synchronously by `reset`.
  - Instantiated only under `CLK_DIV_PROG_DUTY50_EN`; without the macro it is a wire.

## Test plan
- Reset default: hold `reset` 2 cycles, `en`=1, DEFAULT_DIV=5.
  - Period must be 5 cycles, with `tick` every 5 cycles.
  - Without the macro, high 3 / low 2; with the macro, high time 2.5 cycles.
- Even divisor: load 8 mid-period.
  - The current 5-cycle period must complete, then periods of 8 cycles with high 4 / low 4.
  - `div_ready` must be low from the edge after the transfer until the edge after the wrap.
- Back-to-back load: drive `div_valid` continuously with 6 then 7.
  - Only 6 is accepted until it is applied.
  - 7 is accepted once `div_ready` returns, and is applied one period later.
- Clamp: load 0 and then 1.
  - `cur_div` must read 2 in both cases.
  - Output must toggle every cycle, with `tick` every 2 cycles.
- Enable gating: drop `en` at `cnt`=2.
  - Outputs must be 0 the next cycle.
  - A pending divisor must be applied immediately.
  - Raising `en` again must give `tick` on the 1st edge.
- Reset mid-operation: assert `reset` while `pend_v`=1 with N=9.
  - All outputs return to their reset values.
  - `cur_div` returns to 5 and the pending 9 is discarded.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants, divisor type and clamp helper for the programmable clock divider.
// Optional feature macro used by this block: CLK_DIV_PROG_DUTY50_EN.
package clk_div_pkg;

  localparam int unsigned DIV_MIN   = 2;
  localparam int          CNT_W_DEF = 8;

  typedef logic [CNT_W_DEF-1:0] div_t;

  // Divisors below the minimum would stall or never wrap, so they are raised to DIV_MIN.
  function automatic int unsigned clamp_div(input int unsigned d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Divisor load handshake between a configuring master and the clock divider.
// Optional feature macro of the divider: CLK_DIV_PROG_DUTY50_EN.
interface clk_div_prog_if
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic [CNT_W-1:0] div_in;
  logic             div_valid;
  logic             div_ready;

  modport master (
    output div_in,
    output div_valid,
    input  div_ready
  );

  modport slave (
    input  div_in,
    input  div_valid,
    output div_ready
  );

endinterface

// File: rtl/clk_div_duty50.sv
// Odd-divisor duty-cycle corrector: stretches the posedge high phase by half a clock
// using a falling-edge copy. Only exists when CLK_DIV_PROG_DUTY50_EN is defined.
`ifdef CLK_DIV_PROG_DUTY50_EN
module clk_div_duty50
  import clk_div_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic hi_pos,
  input  logic odd_pos,
  output logic duty_clk
);

  logic neg_q;

  // Falling-edge copy of the high phase, only for odd divisors so even N keeps its exact split.
  always_ff @(negedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= hi_pos & odd_pos;
    end
  end

  assign duty_clk = hi_pos | neg_q;

endmodule
`endif

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor changes at period
// boundaries. Defining CLK_DIV_PROG_DUTY50_EN gives exact 50% duty for odd divisors.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 5
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  clk_div_prog_if.slave    div_bus,
  output logic             divided_clk,
  output logic             tick,
  output logic [CNT_W-1:0] cur_div
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_cur;
  logic [CNT_W-1:0] div_pend;
  logic             pend_v;
  logic             clk_hi;
  logic [CNT_W-1:0] high_len;
  logic             wrap;
  logic             take;

`ifdef CLK_DIV_PROG_DUTY50_EN
  assign high_len = div_cur >> 1;
`else
  assign high_len = (div_cur >> 1) + {{(CNT_W-1){1'b0}}, div_cur[0]};
`endif

  assign wrap              = (cnt == div_cur - CNT_W'(1));
  assign take              = div_bus.div_valid & ~pend_v;
  assign div_bus.div_ready = ~pend_v;
  assign cur_div           = div_cur;

  // Period counter, active/pending divisor bookkeeping and the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      div_cur  <= CNT_W'(DEFAULT_DIV);
      div_pend <= CNT_W'(DEFAULT_DIV);
      pend_v   <= 1'b0;
      clk_hi   <= 1'b0;
      tick     <= 1'b0;
    end else begin
      clk_hi <= en & (cnt < high_len);
      tick   <= en & (cnt == '0);
      if (!en) begin
        cnt <= '0;
        if (pend_v) begin
          div_cur <= div_pend;
          pend_v  <= 1'b0;
        end
      end else if (wrap) begin
        cnt <= '0;
        if (pend_v) begin
          div_cur <= div_pend;
          pend_v  <= 1'b0;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (take) begin
        div_pend <= CNT_W'(clamp_div(32'(div_bus.div_in)));
        pend_v   <= 1'b1;
      end
    end
  end

`ifdef CLK_DIV_PROG_DUTY50_EN
  logic odd_q;

  // Parity of the divisor that produced the current high-phase sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      odd_q <= 1'b0;
    end else begin
      odd_q <= div_cur[0];
    end
  end

  clk_div_duty50 u_duty50 (
    .clk      (clk),
    .reset    (reset),
    .hi_pos   (clk_hi),
    .odd_pos  (odd_q),
    .duty_clk (divided_clk)
  );
`else
  assign divided_clk = clk_hi;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomised scoreboard bench for clk_div_prog: a period-schedule model predicts every
// output sample, a monitor compares the DUT one step after each rising clock edge.
module tb_clk_div_prog;
  import clk_div_pkg::*;

  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 5;

  typedef struct {
    logic hi;
    logic tk;
    logic odd;
    int   cur;
    logic rdy;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             divided_clk;
  logic             tick;
  logic [CNT_W-1:0] cur_div;

  int total_checks = 0;
  int bad_checks   = 0;

  exp_t     expq[$];
  logic [1:0] sched[$];
  int       m_n;
  int       m_pend;
  bit       m_pend_v;

  clk_div_prog_if #(.CNT_W(CNT_W)) div_bus ();

  clk_div_prog #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .div_bus     (div_bus.slave),
    .divided_clk (divided_clk),
    .tick        (tick),
    .cur_div     (cur_div)
  );

  always #5 clk = ~clk;

  function automatic int highLen(input int n);
`ifdef CLK_DIV_PROG_DUTY50_EN
    return n / 2;
`else
    return (n + 1) / 2;
`endif
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp_v);
    total_checks++;
    if (act != exp_v) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic v, input int d);
    reset             = r;
    en                = e;
    div_bus.div_valid = v;
    div_bus.div_in    = CNT_W'(d);
    @(posedge clk);
    #2;
  endtask

  // Reference model: each period is a precomputed list of N samples; divisor requests
  // are remembered and swapped in when a period list runs out or the divider is idle.
  always @(posedge clk) begin : model
    exp_t       e;
    bit         rdy_before;
    logic [1:0] s;
    if (reset) begin
      m_n      = DEFAULT_DIV;
      m_pend_v = 1'b0;
      sched.delete();
      e = '{hi: 1'b0, tk: 1'b0, odd: 1'b0, cur: DEFAULT_DIV, rdy: 1'b1};
    end else begin
      rdy_before = !m_pend_v;
      s          = 2'b00;
      e.odd      = 1'b0;
      if (en) begin
        if (sched.size() == 0) begin
          for (int i = 0; i < m_n; i++) begin
            sched.push_back({(i < highLen(m_n)), (i == 0)});
          end
        end
        s     = sched.pop_front();
        e.odd = (m_n % 2) == 1;
        if (sched.size() == 0 && m_pend_v) begin
          m_n      = m_pend;
          m_pend_v = 1'b0;
        end
      end else begin
        sched.delete();
        if (m_pend_v) begin
          m_n      = m_pend;
          m_pend_v = 1'b0;
        end
      end
      if (div_bus.div_valid && rdy_before) begin
        m_pend   = (int'(div_bus.div_in) < 2) ? 2 : int'(div_bus.div_in);
        m_pend_v = 1'b1;
      end
      e.hi  = s[1];
      e.tk  = s[0];
      e.cur = m_n;
      e.rdy = !m_pend_v;
    end
    expq.push_back(e);
  end

  // Monitor: pops one predicted sample per clock and compares it with the DUT outputs.
  always @(posedge clk) begin : monitor
    exp_t e;
    logic exp_hi;
`ifdef CLK_DIV_PROG_DUTY50_EN
    static logic prev_neg = 1'b0;
`endif
    #1;
    if (expq.size() == 0) begin
      checkOutput("scoreboard_empty", 0, 1);
    end else begin
      e = expq.pop_front();
`ifdef CLK_DIV_PROG_DUTY50_EN
      exp_hi   = e.hi | prev_neg;
      prev_neg = e.hi & e.odd;
`else
      exp_hi = e.hi;
`endif
      checkOutput("divided_clk", int'(divided_clk), int'(exp_hi));
      checkOutput("tick", int'(tick), int'(e.tk));
      checkOutput("cur_div", int'(cur_div), e.cur);
      checkOutput("div_ready", int'(div_bus.div_ready), int'(e.rdy));
    end
  end

  initial begin
    int waited;
    reset             = 1'b1;
    en                = 1'b1;
    div_bus.div_valid = 1'b0;
    div_bus.div_in    = '0;

    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 0);
    repeat (12) applyStimulus(1'b0, 1'b1, 1'b0, 0);

    applyStimulus(1'b0, 1'b1, 1'b1, 8);
    repeat (30) applyStimulus(1'b0, 1'b1, 1'b0, 0);

    applyStimulus(1'b0, 1'b1, 1'b1, 6);
    repeat (30) applyStimulus(1'b0, 1'b1, 1'b1, 7);
    repeat (20) applyStimulus(1'b0, 1'b1, 1'b0, 0);

    applyStimulus(1'b0, 1'b1, 1'b1, 0);
    repeat (20) applyStimulus(1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    repeat (12) applyStimulus(1'b0, 1'b1, 1'b0, 0);

    waited = 0;
    while (!tick && waited < 40) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 0);
      waited++;
    end
    checkOutput("tick_wait", int'(tick), 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 0);
    repeat (15) applyStimulus(1'b0, 1'b1, 1'b0, 0);

    applyStimulus(1'b0, 1'b1, 1'b1, 9);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 0);
    repeat (15) applyStimulus(1'b0, 1'b1, 1'b0, 0);

    repeat (400) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 20)));
    end
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
